// File: rtl/frame_gen_pkg.sv
// Shared types, pattern codes and helper functions for the frame pattern generator.
package frame_gen_pkg;

    // Raster timing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } state_t;

    // Implemented pattern codes; 3'b100 and 3'b101 are reserved.
    localparam logic [2:0] SEL_BLACK = 3'b000;
    localparam logic [2:0] SEL_WHITE = 3'b001;
    localparam logic [2:0] SEL_GRAD  = 3'b010;
    localparam logic [2:0] SEL_CHECK = 3'b011;
    localparam logic [2:0] SEL_CUBES = 3'b110;
    localparam logic [2:0] SEL_LOGO  = 3'b111;

    // Auto-cycle successor of a pattern code; anything unexpected restarts at black.
    function automatic logic [2:0] next_pattern(input logic [2:0] cur);
        logic [2:0] nxt;
        case (cur)
            SEL_BLACK: nxt = SEL_WHITE;
            SEL_WHITE: nxt = SEL_GRAD;
            SEL_GRAD:  nxt = SEL_CHECK;
            SEL_CHECK: nxt = SEL_CUBES;
            SEL_CUBES: nxt = SEL_LOGO;
            SEL_LOGO:  nxt = SEL_BLACK;
            default:   nxt = SEL_BLACK;
        endcase
        return nxt;
    endfunction

    // True for codes that map to an implemented pattern.
    function automatic logic sel_is_valid(input logic [2:0] code);
        logic ok;
        case (code)
            3'b100:  ok = 1'b0;
            3'b101:  ok = 1'b0;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pattern_sequencer.sv
// Pattern select owner: pending host request slot, per-pattern frame counter and
// the active sel register, all updated only on the frame_start strobe.
module pattern_sequencer
    import frame_gen_pkg::*;
#(
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_auto_cycle,
    input  logic [2:0] i_sel_req,
    input  logic       i_sel_req_valid,
    output logic [2:0] o_sel,
    output logic       o_sel_err
);

    localparam int CW = $clog2(FRAMES_PER_PATTERN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_PATTERN - 1);

    logic [2:0]    r_sel;
    logic [2:0]    r_pend;
    logic          r_pend_v;
    logic [CW-1:0] r_cnt;
    logic          r_started;
    logic          r_sel_err;

    logic [2:0]    w_sel_next;
    logic [2:0]    w_pend_next;
    logic          w_pend_v_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_started_next;
    logic          w_sel_err_next;
    logic          w_req_ok;

    assign w_req_ok = sel_is_valid(i_sel_req);

    // Next-state for sel, counter and pending slot; a request arriving on the
    // frame_start cycle is kept for the following frame.
    always_comb begin
        w_sel_next     = r_sel;
        w_pend_next    = r_pend;
        w_pend_v_next  = r_pend_v;
        w_cnt_next     = r_cnt;
        w_started_next = r_started;
        w_sel_err_next = i_sel_req_valid && !w_req_ok;

        if (i_frame_start) begin
            // r_cnt is the index of the current frame within its pattern; the
            // very first frame after reset is index 0 without incrementing.
            w_started_next = 1'b1;
            if (r_pend_v) begin
                w_sel_next    = r_pend;
                w_pend_v_next = 1'b0;
                w_cnt_next    = {CW{1'b0}};
            end else if (i_auto_cycle && r_started && (r_cnt == CNT_LAST)) begin
                w_sel_next = next_pattern(r_sel);
                w_cnt_next = {CW{1'b0}};
            end else if (r_started && (r_cnt != CNT_LAST)) begin
                w_cnt_next = r_cnt + 1'b1;
            end else begin
                w_cnt_next = r_cnt;
            end
        end else begin
            w_sel_next = r_sel;
        end

        if (i_sel_req_valid && w_req_ok) begin
            w_pend_next   = i_sel_req;
            w_pend_v_next = 1'b1;
        end else begin
            w_pend_next = w_pend_next;
        end
    end

    // Pattern state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= SEL_BLACK;
            r_pend    <= 3'b000;
            r_pend_v  <= 1'b0;
            r_cnt     <= {CW{1'b0}};
            r_started <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel     <= w_sel_next;
            r_pend    <= w_pend_next;
            r_pend_v  <= w_pend_v_next;
            r_cnt     <= w_cnt_next;
            r_started <= w_started_next;
            r_sel_err <= w_sel_err_next;
        end
    end

    assign o_sel     = r_sel;
    assign o_sel_err = r_sel_err;

endmodule

// File: rtl/frame_timing_sequencer.sv
// Raster timing master: FVAL/LVAL/DVAL with blanking, frame/line strobes,
// frame counter, and the pattern select via pattern_sequencer.
module frame_timing_sequencer
    import frame_gen_pkg::*;
#(
    parameter int DVAL_HIGH          = 640,
    parameter int ROW_COUNT          = 480,
    parameter int H_BLANK            = 32,
    parameter int V_BLANK_CYC        = 8000,
    parameter int FRAME_START_DLY    = 4,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_auto_cycle,
    input  logic [2:0]  i_sel_req,
    input  logic        i_sel_req_valid,
    output logic        o_fval,
    output logic        o_lval,
    output logic        o_dval,
    output logic        o_fval_posedge,
    output logic        o_lval_negedge,
    output logic [2:0]  o_sel,
    output logic        o_sel_err,
    output logic [15:0] o_frame_count,
    output logic        o_busy
);

    // The horizontal counter times LEAD, ACTIVE and HBLANK, so size it for the longest.
    localparam int H_MAX_AB = (DVAL_HIGH > H_BLANK) ? DVAL_HIGH : H_BLANK;
    localparam int H_MAX    = (H_MAX_AB > FRAME_START_DLY) ? H_MAX_AB : FRAME_START_DLY;
    localparam int HW       = $clog2(H_MAX) + 1;
    localparam int LW       = $clog2(ROW_COUNT) + 1;
    localparam int VW       = $clog2(V_BLANK_CYC) + 1;

    localparam logic [HW-1:0] LEAD_LAST = HW'(FRAME_START_DLY - 1);
    localparam logic [HW-1:0] ACT_LAST  = HW'(DVAL_HIGH - 1);
    localparam logic [HW-1:0] HB_LAST   = HW'(H_BLANK - 1);
    localparam logic [LW-1:0] ROWS      = LW'(ROW_COUNT);
    localparam logic [VW-1:0] VB_LAST   = VW'(V_BLANK_CYC - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [HW-1:0] r_h_cnt;
    logic [HW-1:0] w_h_cnt_next;
    logic [LW-1:0] r_line_cnt;
    logic [LW-1:0] w_line_cnt_next;
    logic [VW-1:0] r_v_cnt;
    logic [VW-1:0] w_v_cnt_next;

    logic          r_fval;
    logic          r_lval;
    logic          r_dval;
    logic          r_fval_posedge;
    logic          r_lval_negedge;
    logic [15:0]   r_frame_count;
    logic          r_busy;

    logic          w_frame_start;
    logic          w_fval_next;
    logic          w_lval_next;
    logic          w_lneg_next;
    logic          w_fc_inc;

    // State register and raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_h_cnt    <= {HW{1'b0}};
            r_line_cnt <= {LW{1'b0}};
            r_v_cnt    <= {VW{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_h_cnt    <= w_h_cnt_next;
            r_line_cnt <= w_line_cnt_next;
            r_v_cnt    <= w_v_cnt_next;
        end
    end

    // Next-state and counter logic; enable is only looked at in IDLE and at the end of VBLANK.
    always_comb begin
        w_state_next    = r_state;
        w_h_cnt_next    = r_h_cnt;
        w_line_cnt_next = r_line_cnt;
        w_v_cnt_next    = r_v_cnt;
        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_state_next    = LEAD;
                    w_h_cnt_next    = {HW{1'b0}};
                    w_line_cnt_next = {LW{1'b0}};
                end else begin
                    w_state_next = IDLE;
                end
            end
            LEAD: begin
                if (r_h_cnt == LEAD_LAST) begin
                    w_state_next = ACTIVE;
                    w_h_cnt_next = {HW{1'b0}};
                end else begin
                    w_h_cnt_next = r_h_cnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (r_h_cnt == ACT_LAST) begin
                    w_state_next    = HBLANK;
                    w_h_cnt_next    = {HW{1'b0}};
                    w_line_cnt_next = r_line_cnt + 1'b1;
                end else begin
                    w_h_cnt_next = r_h_cnt + 1'b1;
                end
            end
            HBLANK: begin
                if (r_h_cnt == HB_LAST) begin
                    w_h_cnt_next = {HW{1'b0}};
                    if (r_line_cnt < ROWS) begin
                        w_state_next = ACTIVE;
                    end else begin
                        w_state_next = VBLANK;
                        w_v_cnt_next = {VW{1'b0}};
                    end
                end else begin
                    w_h_cnt_next = r_h_cnt + 1'b1;
                end
            end
            VBLANK: begin
                if (r_v_cnt == VB_LAST) begin
                    if (i_enable) begin
                        w_state_next    = LEAD;
                        w_h_cnt_next    = {HW{1'b0}};
                        w_line_cnt_next = {LW{1'b0}};
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_v_cnt_next = r_v_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_h_cnt_next    = {HW{1'b0}};
                w_line_cnt_next = {LW{1'b0}};
                w_v_cnt_next    = {VW{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    assign w_frame_start = (w_state_next == LEAD) && (r_state != LEAD);
    assign w_fval_next   = (w_state_next == LEAD) || (w_state_next == ACTIVE) ||
                           (w_state_next == HBLANK);
    assign w_lval_next   = (w_state_next == ACTIVE);
    assign w_lneg_next   = (w_state_next == HBLANK) && (r_state == ACTIVE);
    assign w_fc_inc      = (w_state_next == VBLANK) && (r_state != VBLANK);

    // Registered timing outputs and completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fval         <= 1'b0;
            r_lval         <= 1'b0;
            r_dval         <= 1'b0;
            r_fval_posedge <= 1'b0;
            r_lval_negedge <= 1'b0;
            r_frame_count  <= 16'd0;
            r_busy         <= 1'b0;
        end else begin
            r_fval         <= w_fval_next;
            r_lval         <= w_lval_next;
            r_dval         <= w_lval_next;
            r_fval_posedge <= w_frame_start;
            r_lval_negedge <= w_lneg_next;
            r_busy         <= (w_state_next != IDLE);
            if (w_fc_inc) begin
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_frame_count <= r_frame_count;
            end
        end
    end

    pattern_sequencer #(
        .FRAMES_PER_PATTERN(FRAMES_PER_PATTERN)
    ) u_pattern_sequencer (
        .clk            (clk),
        .rst            (rst),
        .i_frame_start  (w_frame_start),
        .i_auto_cycle   (i_auto_cycle),
        .i_sel_req      (i_sel_req),
        .i_sel_req_valid(i_sel_req_valid),
        .o_sel          (o_sel),
        .o_sel_err      (o_sel_err)
    );

    assign o_fval         = r_fval;
    assign o_lval         = r_lval;
    assign o_dval         = r_dval;
    assign o_fval_posedge = r_fval_posedge;
    assign o_lval_negedge = r_lval_negedge;
    assign o_frame_count  = r_frame_count;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_frame_timing_sequencer.sv
// Bench for frame_timing_sequencer: a frame-position model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_frame_timing_sequencer;

    localparam int DH       = 8;
    localparam int RC       = 4;
    localparam int HB       = 2;
    localparam int VB       = 5;
    localparam int FSD      = 3;
    localparam int FPP      = 2;
    localparam int LINE     = DH + HB;
    localparam int FVAL_LEN = FSD + RC * LINE;
    localparam int PERIOD   = FVAL_LEN + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        auto_cycle = 1'b0;
    logic [2:0]  sel_req = 3'd0;
    logic        sel_req_valid = 1'b0;

    logic        o_fval;
    logic        o_lval;
    logic        o_dval;
    logic        o_fval_posedge;
    logic        o_lval_negedge;
    logic [2:0]  o_sel;
    logic        o_sel_err;
    logic [15:0] o_frame_count;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    frame_timing_sequencer #(
        .DVAL_HIGH(DH), .ROW_COUNT(RC), .H_BLANK(HB), .V_BLANK_CYC(VB),
        .FRAME_START_DLY(FSD), .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(enable), .i_auto_cycle(auto_cycle),
        .i_sel_req(sel_req), .i_sel_req_valid(sel_req_valid),
        .o_fval(o_fval), .o_lval(o_lval), .o_dval(o_dval),
        .o_fval_posedge(o_fval_posedge), .o_lval_negedge(o_lval_negedge),
        .o_sel(o_sel), .o_sel_err(o_sel_err), .o_frame_count(o_frame_count),
        .o_busy(o_busy)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] order_tbl [0:5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    function automatic logic [2:0] model_next(input logic [2:0] s);
        for (int i = 0; i < 6; i++) begin
            if (order_tbl[i] == s) return order_tbl[(i + 1) % 6];
        end
        return 3'd0;
    endfunction

    bit          m_run;
    int          m_p;
    logic [2:0]  m_sel;
    int          m_shown;
    bit          m_pv;
    logic [2:0]  m_pend;
    logic [15:0] m_fc;
    bit          m_err;
    bit          m_start;

    initial begin
        logic e_f, e_l, e_pos, e_neg;
        logic [25:0] act_v, exp_v;
        m_run = 0; m_p = 0; m_sel = 3'd0; m_shown = 0; m_pv = 0;
        m_pend = 3'd0; m_fc = 16'd0; m_err = 0; m_start = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 0; m_p = 0; m_sel = 3'd0; m_shown = 0; m_pv = 0;
                m_pend = 3'd0; m_fc = 16'd0; m_err = 0;
            end else begin
                m_err = sel_req_valid && (sel_req == 3'b100 || sel_req == 3'b101);
                m_start = 0;
                if (!m_run) begin
                    if (enable) begin m_run = 1; m_p = 0; m_start = 1; end
                end else if (m_p == PERIOD - 1) begin
                    if (enable) begin m_p = 0; m_start = 1; end
                    else m_run = 0;
                end else begin
                    m_p++;
                    if (m_p == FVAL_LEN) m_fc = m_fc + 16'd1;
                end
                if (m_start) begin
                    if (m_pv) begin
                        m_sel = m_pend; m_pv = 0; m_shown = 1;
                    end else if (auto_cycle && m_shown >= FPP) begin
                        m_sel = model_next(m_sel); m_shown = 1;
                    end else begin
                        m_shown++;
                    end
                end
                if (sel_req_valid && !(sel_req == 3'b100 || sel_req == 3'b101)) begin
                    m_pend = sel_req; m_pv = 1;
                end
            end
            #1;
            e_f   = m_run && (m_p < FVAL_LEN);
            e_l   = m_run && (m_p >= FSD) && (m_p < FVAL_LEN) && (((m_p - FSD) % LINE) < DH);
            e_pos = m_run && (m_p == 0);
            e_neg = m_run && (m_p >= FSD) && (m_p < FVAL_LEN) && (((m_p - FSD) % LINE) == DH);
            exp_v = {e_f, e_l, e_l, e_pos, e_neg, m_sel, m_err, m_run, m_fc};
            act_v = {o_fval, o_lval, o_dval, o_fval_posedge, o_lval_negedge, o_sel,
                     o_sel_err, o_busy, o_frame_count};
            check("cycle_model", 32'(act_v), 32'(exp_v));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_fpos(input string name);
        bit ok = 0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(posedge clk); #1;
            if (o_fval_posedge) begin ok = 1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Samples one frame starting at the current (fval_posedge) cycle.
    task automatic measure(input int drop_at, output int fh, output int lh, output int neg,
                           output int pos, output int rises, output int dmis);
        logic prev_l = 1'b0;
        fh = 0; lh = 0; neg = 0; pos = 0; rises = 0; dmis = 0;
        for (int c = 0; c < PERIOD; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == drop_at) enable = 1'b0;
            fh    += int'(o_fval);
            lh    += int'(o_lval);
            neg   += int'(o_lval_negedge);
            pos   += int'(o_fval_posedge);
            if (o_lval && !prev_l) rises++;
            if (o_dval !== o_lval) dmis++;
            prev_l = o_lval;
        end
    endtask

    initial begin
        int fh, lh, neg, pos, rises, dmis;
        logic [2:0] exp_seq [0:12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                       3'd6, 3'd6, 3'd7, 3'd7, 3'd0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({o_fval, o_lval, o_dval, o_fval_posedge, o_lval_negedge,
                                 o_sel, o_sel_err, o_frame_count, o_busy}), 32'd0);
        rst = 1'b0; enable = 1'b1; auto_cycle = 1'b1;

        // Frame 1: raster shape.
        wait_fpos("frame1_start");
        check("f1_sel", 32'(o_sel), 32'(exp_seq[0]));
        measure(-1, fh, lh, neg, pos, rises, dmis);
        check("f1_fval_high", 32'(fh), 32'd43);
        check("f1_lval_high", 32'(lh), 32'd32);
        check("f1_lval_rises", 32'(rises), 32'd4);
        check("f1_lval_negedge", 32'(neg), 32'd4);
        check("f1_fval_posedge", 32'(pos), 32'd1);
        check("f1_dval_eq_lval", 32'(dmis), 32'd0);
        @(posedge clk); #1;
        check("period_48", 32'(o_fval_posedge), 32'd1);
        check("f2_frame_count", 32'(o_frame_count), 32'd1);
        check("f2_sel", 32'(o_sel), 32'(exp_seq[1]));

        // Auto-cycle sequence frames 3..13.
        for (int f = 2; f < 13; f++) begin
            wait_fpos("auto_frame_start");
            check("auto_sel", 32'(o_sel), 32'(exp_seq[f]));
        end

        // Host request mid-frame overrides auto step.
        repeat (20) begin @(posedge clk); #1; end
        sel_req = 3'b011; sel_req_valid = 1'b1;
        @(posedge clk); #1;
        sel_req_valid = 1'b0;
        wait_fpos("f14_start");
        check("req_sel_f14", 32'(o_sel), 32'd3);
        wait_fpos("f15_start");
        check("req_hold_f15", 32'(o_sel), 32'd3);
        wait_fpos("f16_start");
        check("auto_after_req_f16", 32'(o_sel), 32'd6);

        // Invalid request.
        repeat (10) begin @(posedge clk); #1; end
        sel_req = 3'b101; sel_req_valid = 1'b1;
        @(posedge clk); #1;
        sel_req_valid = 1'b0;
        check("sel_err_pulse", 32'(o_sel_err), 32'd1);
        @(posedge clk); #1;
        check("sel_err_clear", 32'(o_sel_err), 32'd0);
        wait_fpos("f17_start");
        check("sel_after_invalid", 32'(o_sel), 32'd6);

        // Request on the LEAD-entry cycle applies one frame later.
        repeat (PERIOD - 1) begin @(posedge clk); #1; end
        sel_req = 3'b001; sel_req_valid = 1'b1;
        @(posedge clk); #1;
        sel_req_valid = 1'b0;
        check("f18_posedge", 32'(o_fval_posedge), 32'd1);
        check("f18_sel_auto", 32'(o_sel), 32'd7);
        wait_fpos("f19_start");
        check("f19_sel_pending", 32'(o_sel), 32'd1);

        // enable dropped at line 2: frame completes, then IDLE.
        measure(20, fh, lh, neg, pos, rises, dmis);
        check("drop_fval_high", 32'(fh), 32'd43);
        check("drop_lval_negedge", 32'(neg), 32'd4);
        @(posedge clk); #1;
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_fval", 32'(o_fval), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        enable = 1'b1;
        wait_fpos("reenable_start");
        check("reenable_frame_count", 32'(o_frame_count), 32'd19);
        check("reenable_sel", 32'(o_sel), 32'd1);

        // Asynchronous reset during ACTIVE.
        repeat (5) begin @(posedge clk); #1; end
        check("pre_reset_lval", 32'(o_lval), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", 32'({o_fval, o_lval, o_dval, o_sel, o_busy, o_frame_count}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_fpos("post_reset_start");
        check("post_reset_sel", 32'(o_sel), 32'd0);
        check("post_reset_fc", 32'(o_frame_count), 32'd0);
        measure(-1, fh, lh, neg, pos, rises, dmis);
        check("post_reset_fval_high", 32'(fh), 32'd43);
        check("post_reset_lval_negedge", 32'(neg), 32'd4);

        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
